mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Sequencer for the execute stage's multi-cycle RV64M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the *W forms).
- Accepts one operation from the execute stage and runs it as an iterative radix-2 shift-add / shift-subtract loop.
- Holds the pipeline through the hazard unit while the loop runs.
- Returns a single sign-corrected 64-bit result.
- Sits beside the single-cycle ALU; the ALU is not touched.

## Interface
- XLEN, 64, operand/result width
- clk  in  1  clock
- reset  in  1  synchronous, active-low (reset==0 clears the block at the clock edge)
- req_valid  in  1  the instruction in execute is an MDU op
- req_op  in  3  mdu_op_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- req_word  in  1  *W variant: operate on srca[31:0]/srcb[31:0], sign-extend bit 31 of the result
- srca, srcb  in  XLEN  forwarded operands
- flush  in  1  pipeline flush (trap, mret, redirect); aborts any operation
- resp_stall  in  1  downstream stalled; result must be held
- req_ready  out  1  state==IDLE
- stall_req  out  1  to the hazard unit; holds F/D/E
- resp_valid  out  1  result available
- resp_data  out  XLEN  result

## Operation
- FSM states: IDLE, BUSY, FIXUP, DONE. Reset state: IDLE. Reset values: resp_valid=0, resp_data=0, counter=0. While reset==0, stall_req=0.
- IDLE:
  - Accept when req_valid && !flush.
  - Latch op and word. Record operand signs per op: signed for MUL, MULH, DIV, REM; MULHSU treats srca as signed only.
  - Store operand absolute values.
  - Set counter to 63, or to 31 if word.
  - Go to BUSY.
- Divide special cases, detected at accept, go IDLE→DONE with the result computed directly:
  - Divide by zero: quotient = all ones (-1); remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - For word ops, both cases are evaluated on 32-bit values.
- BUSY: one radix-2 step per cycle.
  - Multiply: 128-bit accumulator, conditional add, then shift.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - counter==0 → FIXUP; otherwise decrement the counter.
- FIXUP:
  - Negate the result if signs differ. Quotient sign = sa^sb. Remainder takes the dividend's sign. Product sign = sa^sb for MULHSU/MULH/MUL.
  - Select the output: MUL → low 64; MULH* → high 64; DIV* → quotient; REM* → remainder.
  - For word ops, sign-extend bit 31.
  - Write resp_data and go to DONE.
- DONE:
  - resp_valid = !flush.
  - If !resp_stall, go to IDLE. The operation retires in the cycle where DONE && !resp_stall && !flush.
  - resp_data holds until the next FIXUP/special-case write.
- stall_req = (state==IDLE && req_valid && !flush) || state==BUSY || state==FIXUP. It is low in DONE, so execute advances in the retire cycle.
- flush in any state → IDLE at the next edge, with no resp_valid. flush wins over a simultaneous req_valid in IDLE.
- Operands are captured at accept. Later changes to srca/srcb are ignored until the next accept.

## Timing
- Accept cycle = C0.
- 64-bit ops: BUSY C1–C64, FIXUP C65, resp_valid at C66. stall_req is high C0–C65 (66 cycles).
- Word ops: BUSY C1–C32, FIXUP C33, resp_valid at C34.
- Special cases: resp_valid at C1.
- Back-to-back: after retiring at Cn, IDLE at Cn+1; earliest next accept is Cn+1.
- resp_stall during DONE: resp_valid and resp_data stay constant for every stalled cycle.
- reset==0 mid-operation: IDLE and zeroed outputs at the next edge; the operation is lost.

## Structure
- mdu_op_t enum goes in the pipes package, next to the decode control struct. Decode sets it.
- MDU_ITERS = 64 and MDU_ITERS_W = 32 go in common.
- One sub-module, mdu_step: purely combinational single radix-2 step. Inputs: accumulator/remainder, operand, mode. Outputs: next accumulator/remainder and quotient bit.
- mdu_ctrl owns the FSM, counter, sign bookkeeping, special-case detection and the fixup mux.

## Test plan
- MUL srca=7, srcb=-3:
  - resp_data=0xFFFF_FFFF_FFFF_FFEB at C66.
  - stall_req high exactly C0–C65.
  - req_ready low C1–C66.
- DIV -7/2 → 0xFFFF_FFFF_FFFF_FFFD. REM -7/2 → 0xFFFF_FFFF_FFFF_FFFF. MULHU 0xFFFF_FFFF_FFFF_FFFF² → 0xFFFF_FFFF_FFFF_FFFE.
- Special cases (resp_valid at C1):
  - DIVU 5/0 → 0xFFFF_FFFF_FFFF_FFFF.
  - REM 5/0 → 5.
  - DIV 0x8000_0000_0000_0000/-1 → 0x8000_0000_0000_0000.
  - REM of the same operands → 0.
- Word ops:
  - MULW 0x7FFF_FFFF×2 → 0xFFFF_FFFF_FFFF_FFFE at C34.
  - DIVW srca=0x1234_5678_8000_0000, srcb=-1 → 0xFFFF_FFFF_8000_0000 at C1.
- flush at C30 of a DIV:
  - IDLE at C31, no resp_valid, req_ready=1.
  - A new MUL 3×4 accepted at C31 gives 12 at C97.
- Stall and reset:
  - resp_stall=1 for 3 cycles in DONE → resp_valid and resp_data stable for 4 cycles, then IDLE.
  - reset=0 at C20 of BUSY → state IDLE, resp_valid=0, resp_data=0, stall_req=0 next cycle.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg
// Shared types and constants for the multiply/divide sequencer.
//   mdu_op_t     : operation selector driven by decode (RV64M funct3 order)
//   mdu_state_t  : sequencer FSM states
//   XLEN         : operand/result width
//   MDU_ITERS    : radix-2 iterations for full-width operations
//   MDU_ITERS_W  : radix-2 iterations for *W (32-bit) operations
//   CNT_W        : width of the iteration counter
package mdu_ctrl_pkg;

    localparam int XLEN        = 64;
    localparam int MDU_ITERS   = 64;
    localparam int MDU_ITERS_W = 32;
    localparam int CNT_W       = $clog2(MDU_ITERS);

    // Encoding follows funct3 so decode can pass the field straight through.
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mdu_state_t;

    // Every divide/remainder opcode has the top funct3 bit set.
    function automatic logic isDivOp(input mdu_op_t op);
        return op[2];
    endfunction

    function automatic logic isRemOp(input mdu_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

    // MULHSU treats only srca as signed.
    function automatic logic srcaSigned(input mdu_op_t op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) ||
               (op == DIV) || (op == REM);
    endfunction

    function automatic logic srcbSigned(input mdu_op_t op);
        return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step
// One combinational radix-2 iteration, processing operand bits MSB first.
//   i_accum   : current 128-bit product accumulator, or remainder in [63:0]
//   i_operand : multiplicand (multiply) or divisor (divide), magnitude only
//   i_bit     : next multiplier bit (multiply) or next dividend bit (divide)
//   i_isDiv   : 1 = restoring divide step, 0 = shift-add multiply step
//   o_accum   : accumulator/remainder after this step
//   o_qBit    : quotient bit produced by a divide step
module mdu_step
    import mdu_ctrl_pkg::*;
(
    input  logic [2*XLEN-1:0] i_accum,
    input  logic [XLEN-1:0]   i_operand,
    input  logic              i_bit,
    input  logic              i_isDiv,
    output logic [2*XLEN-1:0] o_accum,
    output logic              o_qBit
);

    logic [2*XLEN-1:0] w_shifted;
    logic [XLEN:0]     w_partial;
    logic [XLEN-1:0]   w_diff;

    // Multiply doubles the running product and adds the multiplicand when the
    // current multiplier bit is set. Divide shifts the next dividend bit into
    // the remainder and subtracts the divisor if it fits; the partial
    // remainder needs 65 bits because it can exceed 2^64-1 before subtracting.
    // When the subtract succeeds the true difference is below 2^64, so a
    // 64-bit subtract is exact.
    always_comb begin
        w_shifted = i_accum << 1;
        w_partial = {i_accum[XLEN-1:0], i_bit};
        w_diff    = w_partial[XLEN-1:0] - i_operand;
        o_qBit    = (w_partial >= {1'b0, i_operand});
        if (i_isDiv) begin
            o_accum = {{XLEN{1'b0}}, (o_qBit ? w_diff : w_partial[XLEN-1:0])};
        end else begin
            o_accum = w_shifted + (i_bit ? {{XLEN{1'b0}}, i_operand} : '0);
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl
// Sequencer for multi-cycle RV64M multiply/divide operations in execute.
//   clk, reset  : clock, synchronous active-low reset
//   req_valid   : execute holds an MDU op
//   req_op      : which MDU op (mdu_op_t)
//   req_word    : *W form, operate on the low 32 bits and sign-extend
//   srca, srcb  : forwarded operands, captured on accept
//   flush       : abort whatever is in flight
//   resp_stall  : downstream cannot take the result yet
//   req_ready   : sequencer idle
//   stall_req   : hold F/D/E while an operation is in progress
//   resp_valid  : resp_data holds a finished result
//   resp_data   : sign-corrected result
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  mdu_op_t         req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    input  logic            resp_stall,
    output logic            req_ready,
    output logic            stall_req,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data
);

    mdu_state_t        r_state;
    mdu_state_t        w_nextState;
    mdu_op_t           r_op;
    logic              r_isWord;
    logic              r_negate;
    logic [XLEN-1:0]   r_bits;
    logic [XLEN-1:0]   r_operand;
    logic [2*XLEN-1:0] r_accum;
    logic [XLEN-1:0]   r_quot;
    logic [CNT_W-1:0]  r_count;
    logic [XLEN-1:0]   r_respData;

    logic              w_accept;
    logic              w_aSign;
    logic              w_bSign;
    logic [XLEN-1:0]   w_aMag;
    logic [XLEN-1:0]   w_bMag;
    logic [XLEN-1:0]   w_aExt;
    logic              w_divZero;
    logic              w_divOvf;
    logic              w_special;
    logic [XLEN-1:0]   w_specialResult;
    logic [2*XLEN-1:0] w_stepAccum;
    logic              w_qBit;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_res;
    logic [XLEN-1:0]   w_fixResult;

    mdu_step u_step (
        .i_accum   (r_accum),
        .i_operand (r_operand),
        .i_bit     (r_bits[r_count]),
        .i_isDiv   (isDivOp(r_op)),
        .o_accum   (w_stepAccum),
        .o_qBit    (w_qBit)
    );

    // Operand preparation at accept. Word forms work on the low 32 bits, so
    // sign bits come from bit 31 and magnitudes are zero-extended to 64 bits;
    // the loop then just runs 32 iterations over the low half. The two divide
    // corner cases (divide by zero, most-negative / -1) are spotted here so
    // they can skip the loop and produce the RISC-V defined result directly.
    always_comb begin
        w_aSign = srcaSigned(req_op) && (req_word ? srca[31] : srca[XLEN-1]);
        w_bSign = srcbSigned(req_op) && (req_word ? srcb[31] : srcb[XLEN-1]);
        if (req_word) begin
            w_aMag    = {32'b0, (w_aSign ? -srca[31:0] : srca[31:0])};
            w_bMag    = {32'b0, (w_bSign ? -srcb[31:0] : srcb[31:0])};
            w_aExt    = {{32{srca[31]}}, srca[31:0]};
            w_divZero = (srcb[31:0] == 32'b0);
            w_divOvf  = (srca[31:0] == 32'h8000_0000) && (srcb[31:0] == 32'hFFFF_FFFF);
        end else begin
            w_aMag    = w_aSign ? -srca : srca;
            w_bMag    = w_bSign ? -srcb : srcb;
            w_aExt    = srca;
            w_divZero = (srcb == '0);
            w_divOvf  = (srca == {1'b1, {(XLEN-1){1'b0}}}) && (srcb == '1);
        end
        w_divOvf  = w_divOvf && ((req_op == DIV) || (req_op == REM));
        w_special = isDivOp(req_op) && (w_divZero || w_divOvf);
        if (w_divZero) begin
            w_specialResult = isRemOp(req_op) ? w_aExt : '1;
        end else begin
            w_specialResult = isRemOp(req_op) ? '0 : w_aExt;
        end
    end

    // Result fixup after the loop. The product is negated at full 128-bit
    // width so that MULH/MULHSU get the correct high half. A remainder takes
    // the dividend's sign; quotient and product use sa^sb, and r_negate was
    // already chosen accordingly at accept.
    always_comb begin
        w_prod = r_negate ? -r_accum : r_accum;
        w_quot = r_negate ? -r_quot : r_quot;
        w_rem  = r_negate ? -r_accum[XLEN-1:0] : r_accum[XLEN-1:0];
        case (r_op)
            MUL:                 w_res = w_prod[XLEN-1:0];
            MULH, MULHSU, MULHU: w_res = w_prod[2*XLEN-1:XLEN];
            DIV, DIVU:           w_res = w_quot;
            default:             w_res = w_rem;
        endcase
        w_fixResult = r_isWord ? {{32{w_res[31]}}, w_res[31:0]} : w_res;
    end

    // Next-state and handshake logic. Flush beats everything, including a
    // request arriving in IDLE. stall_req is forced low while reset is held
    // so the hazard unit never sees a stale hold request.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid && !flush) begin
                    w_accept    = 1'b1;
                    w_nextState = w_special ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    w_nextState = IDLE;
                end else if (r_count == '0) begin
                    w_nextState = FIXUP;
                end
            end
            FIXUP: begin
                w_nextState = flush ? IDLE : DONE;
            end
            default: begin
                if (flush || !resp_stall) begin
                    w_nextState = IDLE;
                end
            end
        endcase
        req_ready  = (r_state == IDLE);
        resp_valid = (r_state == DONE) && !flush;
        stall_req  = reset && (w_accept || (r_state == BUSY) || (r_state == FIXUP));
        resp_data  = r_respData;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Datapath registers. On accept the operands are captured as magnitudes:
    // for multiply the multiplier bits drive the loop and the multiplicand is
    // added; for divide the dividend bits are shifted in and the divisor is
    // subtracted. The counter doubles as the bit index, walking MSB to LSB.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op       <= MUL;
            r_isWord   <= 1'b0;
            r_negate   <= 1'b0;
            r_bits     <= '0;
            r_operand  <= '0;
            r_accum    <= '0;
            r_quot     <= '0;
            r_count    <= '0;
            r_respData <= '0;
        end else if (w_accept) begin
            r_op      <= req_op;
            r_isWord  <= req_word;
            r_negate  <= isRemOp(req_op) ? w_aSign : (w_aSign ^ w_bSign);
            r_bits    <= isDivOp(req_op) ? w_aMag : w_bMag;
            r_operand <= isDivOp(req_op) ? w_bMag : w_aMag;
            r_accum   <= '0;
            r_quot    <= '0;
            r_count   <= req_word ? CNT_W'(MDU_ITERS_W - 1) : CNT_W'(MDU_ITERS - 1);
            if (w_special) begin
                r_respData <= w_specialResult;
            end
        end else if ((r_state == BUSY) && !flush) begin
            r_accum <= w_stepAccum;
            r_quot  <= {r_quot[XLEN-2:0], w_qBit};
            if (r_count != '0) begin
                r_count <= r_count - CNT_W'(1);
            end
        end else if ((r_state == FIXUP) && !flush) begin
            r_respData <= w_fixResult;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl
// Directed bench for mdu_ctrl: arithmetic results with hand-computed values,
// cycle-exact latency and handshake, divide corner cases, word forms,
// flush, downstream stall and mid-operation reset.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic            clk;
    logic            reset;
    logic            reqValid;
    mdu_op_t         reqOp;
    logic            reqWord;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic            flush;
    logic            respStall;
    logic            reqReady;
    logic            stallReq;
    logic            respValid;
    logic [XLEN-1:0] respData;

    int errorCount = 0;
    int checkCount = 0;

    mdu_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (reqValid),
        .req_op     (reqOp),
        .req_word   (reqWord),
        .srca       (srcA),
        .srcb       (srcB),
        .flush      (flush),
        .resp_stall (respStall),
        .req_ready  (reqReady),
        .stall_req  (stallReq),
        .resp_valid (respValid),
        .resp_data  (respData)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input mdu_op_t op, input logic word,
                                 input logic [63:0] a, input logic [63:0] b);
        reqValid = valid;
        reqOp    = op;
        reqWord  = word;
        srcA     = a;
        srcB     = b;
    endtask

    // Move 1 ns past the next rising edge; registered outputs are settled.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Accept an op in the current cycle (C0), scramble operands afterwards,
    // and check handshake every cycle up to C<latency> where the result must
    // appear. holdCycles > 0 keeps resp_stall high for that many DONE cycles.
    task automatic runOp(input string tag, input mdu_op_t op, input logic word,
                         input logic [63:0] a, input logic [63:0] b,
                         input int latency, input logic [63:0] expected,
                         input int holdCycles);
        int stallLow;
        int readyHigh;
        int earlyValid;
        int holdBad;
        stallLow   = 0;
        readyHigh  = 0;
        earlyValid = 0;
        holdBad    = 0;
        respStall  = (holdCycles > 0);
        applyStimulus(1'b1, op, word, a, b);
        #1;
        checkOutput({tag, "/stallC0"}, 64'(stallReq), 64'd1);
        nextCycle();
        applyStimulus(1'b0, MUL, 1'b0, ~a, ~b);
        for (int c = 1; c < latency; c++) begin
            #1;
            if (!stallReq) stallLow++;
            if (reqReady) readyHigh++;
            if (respValid) earlyValid++;
            nextCycle();
        end
        #1;
        checkOutput({tag, "/stallLowInLoop"}, 64'(stallLow), 64'd0);
        checkOutput({tag, "/readyHighInLoop"}, 64'(readyHigh), 64'd0);
        checkOutput({tag, "/earlyValid"}, 64'(earlyValid), 64'd0);
        checkOutput({tag, "/valid"}, 64'(respValid), 64'd1);
        checkOutput({tag, "/data"}, respData, expected);
        checkOutput({tag, "/stallDone"}, 64'(stallReq), 64'd0);
        checkOutput({tag, "/readyDone"}, 64'(reqReady), 64'd0);
        for (int k = 0; k < holdCycles; k++) begin
            nextCycle();
            if (k == holdCycles - 1) respStall = 1'b0;
            #1;
            if (!respValid || (respData !== expected)) holdBad++;
        end
        if (holdCycles > 0) begin
            checkOutput({tag, "/heldStable"}, 64'(holdBad), 64'd0);
        end
        nextCycle();
        checkOutput({tag, "/readyAfter"}, 64'(reqReady), 64'd1);
        checkOutput({tag, "/validAfter"}, 64'(respValid), 64'd0);
    endtask

    initial begin
        int sawValid;
        reset     = 1'b0;
        flush     = 1'b0;
        respStall = 1'b0;
        applyStimulus(1'b1, MUL, 1'b0, 64'd1, 64'd1);

        // Reset state, with a request pending to show stall_req is gated.
        nextCycle();
        nextCycle();
        #1;
        checkOutput("reset/ready", 64'(reqReady), 64'd1);
        checkOutput("reset/valid", 64'(respValid), 64'd0);
        checkOutput("reset/data", respData, 64'd0);
        checkOutput("reset/stall", 64'(stallReq), 64'd0);
        applyStimulus(1'b0, MUL, 1'b0, 64'd0, 64'd0);
        reset = 1'b1;
        nextCycle();

        // Full-width arithmetic.
        runOp("mul7xm3",   MUL,    1'b0, 64'd7, -64'sd3, 66, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        runOp("divm7d2",   DIV,    1'b0, -64'sd7, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        runOp("remm7d2",   REM,    1'b0, -64'sd7, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        runOp("mulhuMax",  MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              66, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        runOp("mulhsuM1x2", MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
              66, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        runOp("remu100d7", REMU,   1'b0, 64'd100, 64'd7, 66, 64'd2, 0);

        // Divide corner cases.
        runOp("divuBy0",   DIVU,   1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        runOp("remBy0",    REM,    1'b0, 64'd5, 64'd0, 1, 64'd5, 0);
        runOp("divOvf",    DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              1, 64'h8000_0000_0000_0000, 0);
        runOp("remOvf",    REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              1, 64'd0, 0);

        // Word forms.
        runOp("mulw",      MUL,    1'b1, 64'h7FFF_FFFF, 64'd2, 34, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        runOp("divwOvf",   DIV,    1'b1, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              1, 64'hFFFF_FFFF_8000_0000, 0);
        runOp("divuw",     DIVU,   1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd16, 34, 64'h0FFF_FFFF, 0);
        runOp("remw",      REM,    1'b1, -64'sd7, 64'd2, 34, 64'hFFFF_FFFF_FFFF_FFFF, 0);

        // Downstream stall for three DONE cycles.
        runOp("stallHold", MUL,    1'b0, 64'd3, 64'd5, 66, 64'd15, 3);

        // Flush at C30 of a divide, then a new multiply accepted at C31.
        sawValid = 0;
        applyStimulus(1'b1, DIV, 1'b0, 64'd100, 64'd7);
        nextCycle();
        applyStimulus(1'b0, MUL, 1'b0, 64'd0, 64'd0);
        for (int c = 1; c < 30; c++) begin
            if (respValid) sawValid++;
            nextCycle();
        end
        flush = 1'b1;
        #1;
        if (respValid) sawValid++;
        nextCycle();
        flush = 1'b0;
        #1;
        checkOutput("flush/ready", 64'(reqReady), 64'd1);
        checkOutput("flush/valid", 64'(respValid), 64'd0);
        checkOutput("flush/noValidBefore", 64'(sawValid), 64'd0);
        runOp("mulAfterFlush", MUL, 1'b0, 64'd3, 64'd4, 66, 64'd12, 0);

        // Flush beats a request arriving in IDLE.
        applyStimulus(1'b1, DIVU, 1'b0, 64'd9, 64'd3);
        flush = 1'b1;
        #1;
        checkOutput("flushIdle/stall", 64'(stallReq), 64'd0);
        nextCycle();
        flush = 1'b0;
        applyStimulus(1'b0, MUL, 1'b0, 64'd0, 64'd0);
        #1;
        checkOutput("flushIdle/ready", 64'(reqReady), 64'd1);
        checkOutput("flushIdle/data", respData, 64'd12);

        // Reset asserted at C20 of a multiply.
        applyStimulus(1'b1, MUL, 1'b0, 64'd5, 64'd6);
        nextCycle();
        applyStimulus(1'b0, MUL, 1'b0, 64'd0, 64'd0);
        for (int c = 1; c < 20; c++) nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("midReset/stallComb", 64'(stallReq), 64'd0);
        nextCycle();
        checkOutput("midReset/ready", 64'(reqReady), 64'd1);
        checkOutput("midReset/valid", 64'(respValid), 64'd0);
        checkOutput("midReset/data", respData, 64'd0);
        checkOutput("midReset/stall", 64'(stallReq), 64'd0);
        reset = 1'b1;
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
